// File: rtl/mem_dumper_if.sv
// Memory-read and byte-stream bundle between mem_dumper (master) and the
// data memory / host consumer (slave).
interface mem_dumper_if #(
   parameter int AW = 8,
   parameter int DW = 8
) ();
   logic [AW-1:0] mem_addr;
   logic          mem_rd_en;
   logic [DW-1:0] mem_data;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;

   modport master (
      output mem_addr, mem_rd_en, out_data, out_valid,
      input  mem_data, out_ready
   );

   modport slave (
      input  mem_addr, mem_rd_en, out_data, out_valid,
      output mem_data, out_ready
   );
endinterface

// File: rtl/mem_dumper.sv
// After a rising edge of halt, reads a window of data memory byte by byte and
// streams it over valid/ready while accumulating a 16-bit checksum.
module mem_dumper #(
   parameter int AW = 8,
   parameter int DW = 8,
   parameter int LW = 9
) (
   input  logic          CLK,
   input  logic          reset,
   input  logic          halt,
   input  logic [AW-1:0] dump_base,
   input  logic [LW-1:0] dump_len,
   mem_dumper_if.master  bus,
   output logic          busy,
   output logic          done,
   output logic [15:0]   checksum
);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      SEND,
      DONE
   } state_t;

   state_t        state;
   state_t        state_next;
   logic          halt_d;
   logic [AW-1:0] base;
   logic [LW-1:0] len;
   logic [LW-1:0] count;
   logic          trigger;
   logic          last;

   assign trigger = halt & ~halt_d;
   // count is LW bits so a full-memory window (len = 2^AW) terminates
   assign last    = (count + LW'(1)) == len;

   always_ff @(posedge CLK) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: begin
            if (trigger) begin
               state_next = (dump_len == '0) ? DONE : FETCH;
            end
         end
         FETCH: state_next = SEND;
         SEND: begin
            if (bus.out_ready) begin
               state_next = last ? DONE : FETCH;
            end
         end
         DONE: begin
            if (!halt) begin
               state_next = IDLE;
            end
         end
      endcase
   end

   // halt_d resets high so a halt already asserted out of reset is not an edge
   always_ff @(posedge CLK) begin
      if (reset) begin
         halt_d       <= 1'b1;
         base         <= '0;
         len          <= '0;
         count        <= '0;
         checksum     <= '0;
         bus.out_data <= '0;
      end else begin
         halt_d <= halt;
         unique case (state)
            IDLE: begin
               if (trigger) begin
                  base     <= dump_base;
                  len      <= dump_len;
                  count    <= '0;
                  checksum <= '0;
               end
            end
            FETCH: bus.out_data <= bus.mem_data;
            SEND: begin
               if (bus.out_ready) begin
                  checksum <= checksum + 16'(bus.out_data);
                  count    <= count + LW'(1);
               end
            end
            DONE: ;
         endcase
      end
   end

   always_comb begin
      busy          = 1'b0;
      done          = 1'b0;
      bus.out_valid = 1'b0;
      bus.mem_rd_en = 1'b0;
      bus.mem_addr  = '0;
      unique case (state)
         IDLE: ;
         FETCH: begin
            busy          = 1'b1;
            bus.mem_rd_en = 1'b1;
            bus.mem_addr  = base + AW'(count);
         end
         SEND: begin
            busy          = 1'b1;
            bus.out_valid = 1'b1;
         end
         DONE: done = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_mem_dumper.sv
// Randomized bench for mem_dumper: an address/byte queue model built from the
// memory contents is checked against the DUT every cycle, plus literal pins.
module tb_mem_dumper;
   localparam int AW = 8;
   localparam int DW = 8;
   localparam int LW = 9;

   logic          CLK = 1'b0;
   logic          reset;
   logic          halt;
   logic [AW-1:0] dump_base;
   logic [LW-1:0] dump_len;
   logic          busy;
   logic          done;
   logic [15:0]   checksum;

   int checks   = 0;
   int failures = 0;

   logic [7:0] mem [256];
   logic [7:0] exp_addr[$];
   logic [7:0] exp_bytes[$];

   mem_dumper_if #(.AW(AW), .DW(DW)) bus ();

   mem_dumper #(.AW(AW), .DW(DW), .LW(LW)) dut (
      .CLK       (CLK),
      .reset     (reset),
      .halt      (halt),
      .dump_base (dump_base),
      .dump_len  (dump_len),
      .bus       (bus),
      .busy      (busy),
      .done      (done),
      .checksum  (checksum)
   );

   always #5 CLK = ~CLK;

   assign bus.mem_data = mem[bus.mem_addr];

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Per-cycle compare: fetched addresses, accepted bytes, stall stability
   logic       stall_prev = 1'b0;
   logic [7:0] stall_data = '0;
   always @(negedge CLK) begin
      if (!reset) begin
         if (stall_prev) begin
            chk("stall_valid_held", bus.out_valid, 1);
            chk("stall_data_held", bus.out_data, stall_data);
         end
         if (bus.mem_rd_en) begin
            chk("fetch_expected", exp_addr.size() > 0, 1);
            if (exp_addr.size() > 0) chk("mem_addr", bus.mem_addr, exp_addr.pop_front());
         end
         if (bus.out_valid && bus.out_ready) begin
            chk("byte_expected", exp_bytes.size() > 0, 1);
            if (exp_bytes.size() > 0) chk("out_data", bus.out_data, exp_bytes.pop_front());
         end
      end
      stall_prev <= bus.out_valid && !bus.out_ready && !reset;
      stall_data <= bus.out_data;
   end

   task automatic load_model(input logic [7:0] base, input logic [8:0] len,
                             output logic [15:0] sum);
      exp_addr.delete();
      exp_bytes.delete();
      sum = '0;
      for (int i = 0; i < int'(len); i++) begin
         logic [7:0] a;
         a = base + 8'(i);
         exp_addr.push_back(a);
         exp_bytes.push_back(mem[a]);
         sum = sum + 16'(mem[a]);
      end
   endtask

   // mode 0: ready high; 1: random ready/halt/inputs; 2: 3-cycle stall on byte 2
   task automatic run_dump(input logic [7:0] base, input logic [8:0] len, input int mode,
                           output int cyc, output int vcnt, output int bseen);
      logic [15:0] sum;
      int hs;
      int stall;
      load_model(base, len, sum);
      dump_base     = base;
      dump_len      = len;
      halt          = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge CLK); #1;
      halt = 1'b1;
      @(posedge CLK); #1;
      cyc = 1; vcnt = 0; bseen = 0; hs = 0; stall = 3;
      while (!done && cyc < 2000) begin
         if (busy) bseen = 1;
         case (mode)
            1: bus.out_ready = 1'($urandom_range(0, 1));
            2: begin
               if (bus.out_valid && hs == 1 && stall > 0) begin
                  bus.out_ready = 1'b0;
                  stall--;
               end else begin
                  bus.out_ready = 1'b1;
               end
            end
            default: bus.out_ready = 1'b1;
         endcase
         if (bus.out_valid) vcnt++;
         if (bus.out_valid && bus.out_ready) hs++;
         if (mode == 1) begin
            dump_base = 8'($urandom);
            dump_len  = 9'($urandom);
            halt      = 1'($urandom_range(0, 1));
         end
         @(posedge CLK); #1;
         cyc++;
      end
      chk("done_reached", done, 1);
      chk("checksum_model", checksum, sum);
      chk("bytes_left", exp_bytes.size(), 0);
      chk("addrs_left", exp_addr.size(), 0);
      halt          = 1'b0;
      bus.out_ready = 1'b0;
      @(posedge CLK); #1;
      chk("done_cleared", done, 0);
      chk("checksum_kept", checksum, sum);
   endtask

   initial begin
      int cyc, vcnt, bseen, hs;
      logic [15:0] sum;
      reset         = 1'b1;
      halt          = 1'b1;
      dump_base     = '0;
      dump_len      = '0;
      bus.out_ready = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_rd_en", bus.mem_rd_en, 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_checksum", checksum, 0);
      reset = 1'b0;
      repeat (4) begin
         @(posedge CLK); #1;
         chk("halt_high_no_dump", busy, 0);
      end

      mem[8'h10] = 8'h11; mem[8'h11] = 8'h22; mem[8'h12] = 8'h33; mem[8'h13] = 8'h44;
      run_dump(8'h10, 9'd4, 0, cyc, vcnt, bseen);
      chk("t1_done_latency", cyc, 9);
      chk("t1_valid_cycles", vcnt, 4);

      run_dump(8'h10, 9'd4, 2, cyc, vcnt, bseen);
      chk("t2_valid_cycles", vcnt, 7);
      chk("t2_checksum", checksum, 16'h00AA);

      mem[8'hFE] = 8'd1; mem[8'hFF] = 8'd2; mem[8'h00] = 8'd3; mem[8'h01] = 8'd4;
      run_dump(8'hFE, 9'd4, 0, cyc, vcnt, bseen);
      chk("t3_checksum", checksum, 16'h000A);
      chk("t3_done_latency", cyc, 9);

      run_dump(8'h40, 9'd0, 0, cyc, vcnt, bseen);
      chk("t4_done_latency", cyc, 1);
      chk("t4_busy_seen", bseen, 0);
      chk("t4_valid_seen", vcnt, 0);
      chk("t4_checksum", checksum, 0);

      for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
      run_dump(8'h00, 9'd256, 0, cyc, vcnt, bseen);
      chk("t5_checksum", checksum, 16'hFF00);
      chk("t5_handshakes", vcnt, 256);
      chk("t5_done_latency", cyc, 513);

      // reset during the second byte's SEND
      mem[8'h10] = 8'h11; mem[8'h11] = 8'h22; mem[8'h12] = 8'h33; mem[8'h13] = 8'h44;
      load_model(8'h10, 9'd4, sum);
      dump_base = 8'h10; dump_len = 9'd4; halt = 1'b0; bus.out_ready = 1'b1;
      @(posedge CLK); #1;
      halt = 1'b1;
      @(posedge CLK); #1;
      hs = 0;
      for (int k = 0; k < 20; k++) begin
         if (bus.out_valid && hs == 1) break;
         if (bus.out_valid) hs++;
         @(posedge CLK); #1;
      end
      chk("t6_in_second_send", bus.out_valid && hs == 1, 1);
      reset = 1'b1;
      bus.out_ready = 1'b0;
      @(posedge CLK); #1;
      exp_addr.delete();
      exp_bytes.delete();
      chk("t6_mem_addr", bus.mem_addr, 0);
      chk("t6_rd_en", bus.mem_rd_en, 0);
      chk("t6_out_data", bus.out_data, 0);
      chk("t6_out_valid", bus.out_valid, 0);
      chk("t6_busy", busy, 0);
      chk("t6_done", done, 0);
      chk("t6_checksum", checksum, 0);
      reset = 1'b0;
      repeat (5) begin
         @(posedge CLK); #1;
         chk("t6_no_redump", busy | done, 0);
      end
      run_dump(8'h10, 9'd4, 0, cyc, vcnt, bseen);
      chk("t6_restart_checksum", checksum, 16'h00AA);
      chk("t6_restart_latency", cyc, 9);

      for (int r = 0; r < 12; r++) begin
         for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
         run_dump(8'($urandom), 9'($urandom_range(1, 60)), 1, cyc, vcnt, bseen);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mem_dumper.md
Name: mem_dumper

Overview:
- Host-side reader for the processor's data memory; the processor is the writer of that memory.
- Waits for the processor to assert halt, then reads a programmed window of data memory one byte at a time.
- Streams the bytes out over a valid/ready interface to the testbench or host.
- Keeps a running checksum so the bench can compare results against a golden value without per-byte checking.

Parameters:
- AW, 8, data memory address width (bits).
- DW, 8, data memory word width (bits).
- LW, 9, width of the length field; holds 0..2^AW inclusive.

Ports:
- CLK  input  1  clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- halt  input  1  processor done flag.
- dump_base  input  AW  first address of the window; sampled on the dump trigger.
- dump_len  input  LW  number of bytes to dump; sampled on the dump trigger.
- mem_addr  output  AW  address to data memory.
- mem_rd_en  output  1  read enable to data memory.
- mem_data  input  DW  data memory DataOut; combinational read of mem_addr.
- out_data  output  DW  streamed byte.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts out_data.
- busy  output  1  dump in progress.
- done  output  1  dump complete.
- checksum  output  16  sum of all accepted bytes, mod 2^16.

Behaviour:
- Reset (synchronous, active-high, overrides everything, including mid-dump):
  - state=IDLE.
  - mem_addr=0, mem_rd_en=0, out_data=0, out_valid=0.
  - busy=0, done=0, checksum=0, byte counter=0.
  - halt_d (registered copy of halt) = 1, so a halt already high out of reset does not trigger a dump.
- Trigger:
  - A trigger is a rising edge of halt: halt=1 and halt_d=0.
  - Detected only in IDLE; ignored in every other state.
- States:
  - IDLE:
    - On trigger, latch base=dump_base, len=dump_len, count=0, checksum=0.
    - If len==0, go to DONE; otherwise go to FETCH.
  - FETCH (busy=1, mem_rd_en=1, mem_addr=base+count, truncated to AW bits so the address wraps mod 2^AW):
    - Register out_data<=mem_data.
    - Go to SEND.
    - Lasts exactly 1 cycle.
  - SEND (busy=1, out_valid=1, mem_rd_en=0):
    - out_data is held stable while out_valid=1 and out_ready=0.
    - On a handshake (out_valid & out_ready): checksum<=checksum+out_data (mod 2^16) and count<=count+1.
    - After the handshake, go to DONE if count+1==len, otherwise go to FETCH.
  - DONE (done=1, busy=0, out_valid=0):
    - Holds until halt=0, then goes to IDLE.
    - checksum stays valid in DONE and in the following IDLE until the next trigger clears it.
- Latency:
  - Trigger sampled at edge N: FETCH in cycle N+1, out_valid=1 in cycle N+2.
  - With out_ready tied high, one byte every 2 cycles.
  - len=L, ready always high: done rises 2L+1 cycles after the trigger edge.
- Window crossing the top of memory: base=0xFE, len=4 reads 0xFE, 0xFF, 0x00, 0x01.
- len=256 with base=0 reads the whole memory; count must be LW bits wide.
- dump_base/dump_len changing during a dump: no effect.
- halt dropping mid-dump: the dump still completes. The DONE→IDLE exit occurs on the first cycle halt=0 after done is reached.
- Simultaneous reset and trigger: reset wins; no dump starts.
- Data memory writes are not expected during a dump (processor halted); if they occur, contents are not guaranteed.

Test Plan:
- Preload mem[0x10..0x13]=0x11,0x22,0x33,0x44; dump_base=0x10, len=4; pulse halt 0→1, ready high → out_data sequence 11,22,33,44; each out_valid lasts 1 cycle; done rises 9 cycles after the trigger edge; checksum=0x00AA.
- Same setup with out_ready low for 3 cycles on the second byte → out_data holds 0x22 and out_valid stays 1 for 4 cycles; no duplicate or dropped bytes; checksum=0x00AA.
- dump_base=0xFE, len=4, mem[FE,FF,00,01]=1,2,3,4 → mem_addr sequence FE,FF,00,01; checksum=0x000A.
- len=0 → busy never rises; out_valid never rises; done=1 the cycle after the trigger; checksum=0.
- len=256, base=0, mem[i]=0xFF for all i → 256 handshakes; checksum=0xFF00; done asserts.
- Reset asserted in the middle of the second byte's SEND → next cycle all outputs 0, state IDLE; halt held high afterwards causes no new dump; toggling halt 0→1 restarts a dump from dump_base.
